ctrl_pipe_unit: RTL and testbench

Pipelined successor to the combinational control decoder in the 3-stage RISC-V core. Decodes the fetched instruction, registers the control bundle into the execute stage, carries writeback controls through a parametrised delay line, and handles flush, hold and load-use bubble insertion. Sits between the fetch register and the datapath; replaces the separate main and ALU decoders at the top level.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 81 ++++++++
 rtl/ctrl_pipe_unit.sv | 130 +++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU and ImmSrc constants plus the control bundles carried
// from decode through the E register and the writeback delay line.
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       result_src;
      logic       branch;
      logic       illegal;
      logic [1:0] imm_src;
      logic [3:0] alu_control;
      logic [4:0] rd;
   } ctrl_t;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       result_src;
      logic [4:0] rd;
   } wb_t;

   // alt is funct7[5] already qualified by the caller (I-type only honours it for shifts)
   function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLT;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder: control bundle plus the source
// register fields and which of them the opcode actually reads.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        rs1_used,
   output logic        rs2_used
);

   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   logic       unused_s;

   assign opcode_s = instr[6:0];
   assign funct3_s = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign unused_s = ^{instr[31], instr[29:25]};

   // Main decode; rd is reported only for opcodes that write the register file
   always_comb begin
      ctrl     = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      if (instr_valid) begin
         ctrl.valid = 1'b1;
         case (opcode_s)
            OP_R: begin
               ctrl.reg_write   = 1'b1;
               ctrl.alu_control = alu_op(funct3_s, instr[30]);
               ctrl.rd          = instr[11:7];
               rs1_used         = 1'b1;
               rs2_used         = 1'b1;
            end
            OP_IALU: begin
               ctrl.reg_write   = 1'b1;
               ctrl.alu_src     = 1'b1;
               ctrl.imm_src     = IMM_I;
               ctrl.alu_control = alu_op(funct3_s, (funct3_s == 3'b101) && instr[30]);
               ctrl.rd          = instr[11:7];
               rs1_used         = 1'b1;
            end
            OP_LOAD: begin
               ctrl.reg_write   = 1'b1;
               ctrl.alu_src     = 1'b1;
               ctrl.result_src  = 1'b1;
               ctrl.imm_src     = IMM_I;
               ctrl.alu_control = ALU_ADD;
               ctrl.rd          = instr[11:7];
               rs1_used         = 1'b1;
            end
            OP_STORE: begin
               ctrl.mem_write   = 1'b1;
               ctrl.alu_src     = 1'b1;
               ctrl.imm_src     = IMM_S;
               ctrl.alu_control = ALU_ADD;
               rs1_used         = 1'b1;
               rs2_used         = 1'b1;
            end
            OP_BRANCH: begin
               ctrl.branch      = 1'b1;
               ctrl.imm_src     = IMM_B;
               ctrl.alu_control = ALU_SUB;
               rs1_used         = 1'b1;
               rs2_used         = 1'b1;
            end
            default: begin
               ctrl.illegal = 1'b1;
            end
         endcase
      end else begin
         ctrl = '0;
      end
   end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decode, E-stage control register, writeback delay
// line and flush/hold/load-use handling. CTRL_HAZARD_EN enables load-use stalls.
module ctrl_pipe_unit
   import ctrl_pkg::*;
#(
   parameter int ALUCTRL_W = 4,
   parameter int WB_DELAY  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   input  logic [31:0]          instr,
   input  logic                 hold,
   input  logic                 flush,
   output logic                 stall_req,
   output logic                 e_valid,
   output logic                 e_reg_write,
   output logic                 e_alu_src,
   output logic                 e_mem_write,
   output logic                 e_result_src,
   output logic                 e_branch,
   output logic                 e_illegal,
   output logic [1:0]           e_imm_src,
   output logic [ALUCTRL_W-1:0] e_alu_control,
   output logic [4:0]           e_rd,
   output logic                 w_valid,
   output logic                 w_reg_write,
   output logic                 w_result_src,
   output logic [4:0]           w_rd
);

   ctrl_t      dec_s;
   ctrl_t      e_r;
   wb_t        wb_in_s;
   wb_t        wb_r [WB_DELAY];
   logic [4:0] rs1_s;
   logic [4:0] rs2_s;
   logic       rs1_used_s;
   logic       rs2_used_s;
   logic       load_use_s;
   logic [ALUCTRL_W-1:0] alu_ext_s;

   ctrl_decode u_decode (
      .instr_valid (instr_valid),
      .instr       (instr),
      .ctrl        (dec_s),
      .rs1         (rs1_s),
      .rs2         (rs2_s),
      .rs1_used    (rs1_used_s),
      .rs2_used    (rs2_used_s)
   );

`ifdef CTRL_HAZARD_EN
   // A load in E whose rd is read by the incoming instruction
   always_comb begin
      load_use_s = 1'b0;
      if (e_r.valid && e_r.result_src && (e_r.rd != 5'd0) && instr_valid) begin
         load_use_s = (rs1_used_s && (rs1_s == e_r.rd)) ||
                      (rs2_used_s && (rs2_s == e_r.rd));
      end else begin
         load_use_s = 1'b0;
      end
   end
`else
   logic unused_hz_s;
   assign unused_hz_s = ^{rs1_s, rs2_s, rs1_used_s, rs2_used_s};
   assign load_use_s  = 1'b0;
`endif

   assign stall_req = load_use_s && !flush && !hold;

   // E register: flush beats hold, hold beats load-use bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_r <= '0;
      end else if (flush) begin
         e_r <= '0;
      end else if (hold) begin
         e_r <= e_r;
      end else if (load_use_s) begin
         e_r <= '0;
      end else begin
         e_r <= dec_s;
      end
   end

   assign wb_in_s = '{valid: e_r.valid, reg_write: e_r.reg_write,
                      result_src: e_r.result_src, rd: e_r.rd};

   // Writeback delay line advances on every non-hold cycle, flush included
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < WB_DELAY; i++) begin
            wb_r[i] <= '0;
         end
      end else if (!hold) begin
         wb_r[0] <= wb_in_s;
         for (int i = 1; i < WB_DELAY; i++) begin
            wb_r[i] <= wb_r[i-1];
         end
      end else begin
         for (int i = 0; i < WB_DELAY; i++) begin
            wb_r[i] <= wb_r[i];
         end
      end
   end

   // Zero-extend the 4-bit ALU code to the configured width
   always_comb begin
      alu_ext_s      = '0;
      alu_ext_s[3:0] = e_r.alu_control;
   end

   assign e_valid       = e_r.valid;
   assign e_reg_write   = e_r.reg_write;
   assign e_alu_src     = e_r.alu_src;
   assign e_mem_write   = e_r.mem_write;
   assign e_result_src  = e_r.result_src;
   assign e_branch      = e_r.branch;
   assign e_illegal     = e_r.illegal;
   assign e_imm_src     = e_r.imm_src;
   assign e_alu_control = alu_ext_s;
   assign e_rd          = e_r.rd;

   assign w_valid      = wb_r[WB_DELAY-1].valid;
   assign w_reg_write  = wb_r[WB_DELAY-1].reg_write;
   assign w_result_src = wb_r[WB_DELAY-1].result_src;
   assign w_rd         = wb_r[WB_DELAY-1].rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed self-checking bench for ctrl_pipe_unit (ALUCTRL_W=4, WB_DELAY=1);
// load-use expectations follow CTRL_HAZARD_EN.
module tb_ctrl_pipe_unit;

   localparam logic [31:0] I_ADD3   = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_SRAI5  = 32'h40235293; // srai x5,x6,2
   localparam logic [31:0] I_SUB8   = 32'h40208433; // sub  x8,x1,x2
   localparam logic [31:0] I_ADDI9  = 32'h40008493; // addi x9,x1,1024
   localparam logic [31:0] I_BEQ    = 32'h00208063; // beq  x1,x2,0
   localparam logic [31:0] I_LW4    = 32'h0000A203; // lw   x4,0(x1)
   localparam logic [31:0] I_ADD7   = 32'h002203B3; // add  x7,x4,x2
   localparam logic [31:0] I_LW0    = 32'h0000A003; // lw   x0,0(x1)
   localparam logic [31:0] I_ADD700 = 32'h000003B3; // add  x7,x0,x0
   localparam logic [31:0] I_SW     = 32'h00512423; // sw   x5,8(x2)
   localparam logic [31:0] I_ILL    = 32'h0000007F;

`ifdef CTRL_HAZARD_EN
   localparam logic HZ = 1'b1;
`else
   localparam logic HZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic        stall_req;
   logic        e_valid, e_reg_write, e_alu_src, e_mem_write, e_result_src, e_branch, e_illegal;
   logic [1:0]  e_imm_src;
   logic [3:0]  e_alu_control;
   logic [4:0]  e_rd;
   logic        w_valid, w_reg_write, w_result_src;
   logic [4:0]  w_rd;

   int n_cmp = 0;
   int n_bad = 0;

   ctrl_pipe_unit #(.ALUCTRL_W(4), .WB_DELAY(1)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .hold(hold), .flush(flush), .stall_req(stall_req),
      .e_valid(e_valid), .e_reg_write(e_reg_write), .e_alu_src(e_alu_src),
      .e_mem_write(e_mem_write), .e_result_src(e_result_src), .e_branch(e_branch),
      .e_illegal(e_illegal), .e_imm_src(e_imm_src), .e_alu_control(e_alu_control),
      .e_rd(e_rd), .w_valid(w_valid), .w_reg_write(w_reg_write),
      .w_result_src(w_result_src), .w_rd(w_rd)
   );

   always #5 clk = ~clk;

   // Expected E vector: v rw as mw rs br il imm[2] alu[4] rd[5]
   function automatic logic [17:0] ev(input logic v, rw, as, mw, rs, br, il,
                                      input logic [1:0] imm, input logic [3:0] alu,
                                      input logic [4:0] rd);
      return {v, rw, as, mw, rs, br, il, imm, alu, rd};
   endfunction

   function automatic logic [7:0] wv(input logic v, rw, rs, input logic [4:0] rd);
      return {v, rw, rs, rd};
   endfunction

   task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h, required %h", tag, got, exp);
      end
   endtask

   task automatic chk_e(input string tag, input logic [17:0] exp);
      chk(tag, {e_valid, e_reg_write, e_alu_src, e_mem_write, e_result_src, e_branch,
                e_illegal, e_imm_src, e_alu_control, e_rd}, exp);
   endtask

   task automatic chk_w(input string tag, input logic [7:0] exp);
      chk(tag, {10'd0, w_valid, w_reg_write, w_result_src, w_rd}, {10'd0, exp});
   endtask

   task automatic chk_s(input string tag, input logic exp);
      chk(tag, {17'd0, stall_req}, {17'd0, exp});
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic h, input logic f);
      instr_valid = v;
      instr       = i;
      hold        = h;
      flush       = f;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (2) tick;
      chk_e("reset_e", 18'd0);
      chk_w("reset_w", 8'd0);
      chk_s("reset_stall", 1'b0);
      rst = 1'b1;

      drive(1'b1, I_ADD3, 1'b0, 1'b0);
      chk_s("add_nostall", 1'b0);
      tick;
      chk_e("add_e", ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 5'd3));
      drive(1'b1, I_SRAI5, 1'b0, 1'b0);
      tick;
      chk_e("srai_e", ev(1, 1, 1, 0, 0, 0, 0, 2'b00, 4'b1000, 5'd5));
      chk_w("add_w", wv(1, 1, 0, 5'd3));
      drive(1'b1, I_SUB8, 1'b0, 1'b0);
      tick;
      chk_e("sub_e", ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 5'd8));
      chk_w("srai_w", wv(1, 1, 0, 5'd5));
      drive(1'b1, I_ADDI9, 1'b0, 1'b0);
      tick;
      chk_e("addi_bit30_e", ev(1, 1, 1, 0, 0, 0, 0, 2'b00, 4'b0000, 5'd9));
      drive(1'b1, I_BEQ, 1'b0, 1'b0);
      tick;
      chk_e("beq_e", ev(1, 0, 0, 0, 0, 1, 0, 2'b10, 4'b0001, 5'd0));

      // load-use pair
      drive(1'b1, I_LW4, 1'b0, 1'b0);
      tick;
      chk_e("lw_e", ev(1, 1, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 5'd4));
      drive(1'b1, I_ADD7, 1'b0, 1'b0);
      chk_s("lu_stall", HZ);
      tick;
      chk_w("lw_w", wv(1, 1, 1, 5'd4));
      if (HZ) begin
         chk_e("lu_bubble", 18'd0);
         chk_s("lu_stall_once", 1'b0);
         tick;
      end
      chk_e("lu_add_e", ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 5'd7));

      // load-use with flush
      drive(1'b1, I_LW4, 1'b0, 1'b0);
      tick;
      drive(1'b1, I_ADD7, 1'b0, 1'b1);
      chk_s("flush_nostall", 1'b0);
      tick;
      chk_e("flush_bubble", 18'd0);
      chk_w("flush_lw_w", wv(1, 1, 1, 5'd4));

      // load to x0 never stalls
      drive(1'b1, I_LW0, 1'b0, 1'b0);
      tick;
      drive(1'b1, I_ADD700, 1'b0, 1'b0);
      chk_s("x0_nostall", 1'b0);

      // load-use under hold, then released
      drive(1'b1, I_LW4, 1'b0, 1'b0);
      tick;
      drive(1'b1, I_ADD7, 1'b1, 1'b0);
      chk_s("hold_nostall", 1'b0);
      tick;
      chk_e("hold_lw_kept", ev(1, 1, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 5'd4));
      drive(1'b1, I_ADD7, 1'b0, 1'b0);
      chk_s("unhold_stall", HZ);
      tick;
      if (HZ) begin
         chk_e("unhold_bubble", 18'd0);
         tick;
      end
      chk_e("unhold_add_e", ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 5'd7));

      // hold with a store in E
      drive(1'b1, I_ADD3, 1'b0, 1'b0);
      tick;
      drive(1'b1, I_SW, 1'b0, 1'b0);
      tick;
      chk_e("sw_e", ev(1, 0, 1, 1, 0, 0, 0, 2'b01, 4'b0000, 5'd0));
      chk_w("sw_prev_w", wv(1, 1, 0, 5'd3));
      drive(1'b1, I_BEQ, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk_e("hold_e", ev(1, 0, 1, 1, 0, 0, 0, 2'b01, 4'b0000, 5'd0));
         chk_w("hold_w", wv(1, 1, 0, 5'd3));
      end
      drive(1'b1, I_BEQ, 1'b0, 1'b0);
      tick;
      chk_e("resume_beq_e", ev(1, 0, 0, 0, 0, 1, 0, 2'b10, 4'b0001, 5'd0));
      chk_w("resume_sw_w", wv(1, 0, 0, 5'd0));
      drive(1'b0, I_ADD3, 1'b0, 1'b0);
      tick;
      chk_e("invalid_bubble", 18'd0);
      chk_w("resume_beq_w", wv(1, 0, 0, 5'd0));

      // illegal opcode
      drive(1'b1, I_ILL, 1'b0, 1'b0);
      tick;
      chk_e("illegal_e", ev(1, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0000, 5'd0));
      drive(1'b1, I_ADD3, 1'b0, 1'b0);
      tick;
      chk_w("illegal_w", wv(1, 0, 0, 5'd0));

      // asynchronous reset mid-stream
      #2 rst = 1'b0;
      #1;
      chk_e("midreset_e", 18'd0);
      chk_w("midreset_w", 8'd0);
      drive(1'b1, I_LW4, 1'b0, 1'b0);
      tick;
      chk_e("midreset_held", 18'd0);
      rst = 1'b1;
      tick;
      chk_e("after_reset_lw", ev(1, 1, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 5'd4));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
